// File: rtl/vend_engine_multi.sv
// Multi-item vending engine: coin credit with ceiling, purchase settlement against per-item
// stock, greedy coin-by-coin change payout, cancel/timeout refund and error hold.
module vend_engine_multi #(
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned MAX_STOCK   = 9,
  parameter int unsigned MAX_CREDIT  = 99,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned ERR_HOLD    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin_pulse,
  input  logic [CREDIT_W-1:0]           coin_value,
  input  logic                          purchase,
  input  logic                          cancel,
  input  logic                          restock,
  input  logic [SEL_W-1:0]              item_sel,
  input  logic [NUM_ITEMS*CREDIT_W-1:0] price_flat,
  input  logic                          chg_ready,
  output logic                          chg_valid,
  output logic [2:0]                    chg_coin,
  output logic [CREDIT_W-1:0]           credit,
  output logic [2:0]                    state,
  output logic                          vend_pulse,
  output logic [SEL_W-1:0]              vend_item,
  output logic                          coin_reject,
  output logic                          error_pulse,
  output logic [1:0]                    err_code,
  output logic [STOCK_W-1:0]            stock_sel,
  output logic [NUM_ITEMS-1:0]          sold_out_mask
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCredit = 3'd1,
    StVend   = 3'd2,
    StChange = 3'd3,
    StError  = 3'd4
  } state_e;

  // One counter serves both the CREDIT inactivity timer and the ERROR hold timer.
  localparam int unsigned CntMax = (TIMEOUT_CYC > ERR_HOLD) ? TIMEOUT_CYC : ERR_HOLD;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] HoldLast    = CntW'(ERR_HOLD - 1);
  localparam logic [CREDIT_W:0] MaxCreditW = (CREDIT_W + 1)'(MAX_CREDIT);

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]      item_q, item_d;
  logic [CREDIT_W-1:0]   price_q, price_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  coin_reject_q, coin_reject_d;
  logic [STOCK_W-1:0]    stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]    stock_d [NUM_ITEMS];

  logic [STOCK_W-1:0]    sel_stock;
  logic [CREDIT_W-1:0]   sel_price;
  logic [CREDIT_W:0]     coin_sum;
  logic                  coin_fits;
  logic [2:0]            greedy_coin;
  logic [CREDIT_W-1:0]   chg_remain;

  always_comb begin
    sel_stock = '0;
    sel_price = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (item_sel == SEL_W'(i)) begin
        sel_stock = stock_q[i];
        sel_price = price_flat[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  always_comb begin
    coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
    coin_fits = (coin_sum <= MaxCreditW);
    if (credit_q >= CREDIT_W'(5)) begin
      greedy_coin = 3'd5;
    end else if (credit_q >= CREDIT_W'(2)) begin
      greedy_coin = 3'd2;
    end else begin
      greedy_coin = 3'd1;
    end
    chg_remain = credit_q - CREDIT_W'(greedy_coin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q      <= '0;
      cnt_q         <= '0;
      item_q        <= '0;
      price_q       <= '0;
      err_code_q    <= '0;
      coin_reject_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(MAX_STOCK);
      end
    end else begin
      credit_q      <= credit_d;
      cnt_q         <= cnt_d;
      item_q        <= item_d;
      price_q       <= price_d;
      err_code_q    <= err_code_d;
      coin_reject_q <= coin_reject_d;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= stock_d[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    cnt_d         = '0;
    item_d        = item_q;
    price_d       = price_q;
    err_code_d    = err_code_q;
    coin_reject_d = 1'b0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (coin_pulse) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = StCredit;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      StCredit: begin
        if (cancel) begin
          coin_reject_d = coin_pulse;
          state_d       = StChange;
        end else if (coin_pulse) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (purchase) begin
          item_d  = item_sel;
          price_d = sel_price;
          if (sel_stock == '0) begin
            state_d    = StError;
            err_code_d = 2'd1;
          end else if (credit_q < sel_price) begin
            state_d    = StError;
            err_code_d = 2'd2;
          end else begin
            state_d = StVend;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d = StChange;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StVend: begin
        coin_reject_d = coin_pulse;
        credit_d      = credit_q - price_q;
        state_d       = (credit_q != price_q) ? StChange : StIdle;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
          if (item_q == SEL_W'(i) && stock_q[i] != '0) begin
            stock_d[i] = stock_q[i] - STOCK_W'(1);
          end
        end
      end
      StChange: begin
        coin_reject_d = coin_pulse;
        if (credit_q == '0) begin
          state_d = StIdle;
        end else if (chg_ready) begin
          credit_d = chg_remain;
          if (chg_remain == '0) begin
            state_d = StIdle;
          end
        end
      end
      StError: begin
        coin_reject_d = coin_pulse;
        if (cnt_q == HoldLast) begin
          state_d = (credit_q != '0) ? StCredit : StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Restock overrides any decrement made by a coincident VEND.
    if (restock) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_d[i] = STOCK_W'(MAX_STOCK);
      end
    end
  end

  always_comb begin
    state       = state_q;
    credit      = credit_q;
    chg_valid   = (state_q == StChange) && (credit_q != '0);
    chg_coin    = chg_valid ? greedy_coin : 3'd0;
    vend_pulse  = (state_q == StVend);
    vend_item   = vend_pulse ? item_q : '0;
    error_pulse = (state_q == StError) && (cnt_q == '0);
    err_code    = err_code_q;
    coin_reject = coin_reject_q;
    stock_sel   = sel_stock;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      sold_out_mask[i] = (stock_q[i] == '0);
    end
  end

endmodule

// File: tb/tb_vend_engine_multi.sv
// Directed bench for vend_engine_multi: an integer-level transaction model is compared
// against every DUT output each cycle, plus hand-computed literal checkpoints.
module tb_vend_engine_multi;

  localparam int NUM_ITEMS   = 4;
  localparam int SEL_W       = 2;
  localparam int CREDIT_W    = 8;
  localparam int STOCK_W     = 4;
  localparam int MAX_STOCK   = 9;
  localparam int MAX_CREDIT  = 99;
  localparam int TIMEOUT_CYC = 1000;
  localparam int ERR_HOLD    = 16;

  logic                          clk;
  logic                          rst;
  logic                          coin_pulse;
  logic [CREDIT_W-1:0]           coin_value;
  logic                          purchase;
  logic                          cancel;
  logic                          restock;
  logic [SEL_W-1:0]              item_sel;
  logic [NUM_ITEMS*CREDIT_W-1:0] price_flat;
  logic                          chg_ready;
  logic                          chg_valid;
  logic [2:0]                    chg_coin;
  logic [CREDIT_W-1:0]           credit;
  logic [2:0]                    state;
  logic                          vend_pulse;
  logic [SEL_W-1:0]              vend_item;
  logic                          coin_reject;
  logic                          error_pulse;
  logic [1:0]                    err_code;
  logic [STOCK_W-1:0]            stock_sel;
  logic [NUM_ITEMS-1:0]          sold_out_mask;

  vend_engine_multi #(
    .NUM_ITEMS  (NUM_ITEMS),
    .SEL_W      (SEL_W),
    .CREDIT_W   (CREDIT_W),
    .STOCK_W    (STOCK_W),
    .MAX_STOCK  (MAX_STOCK),
    .MAX_CREDIT (MAX_CREDIT),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .ERR_HOLD   (ERR_HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_pulse   (coin_pulse),
    .coin_value   (coin_value),
    .purchase     (purchase),
    .cancel       (cancel),
    .restock      (restock),
    .item_sel     (item_sel),
    .price_flat   (price_flat),
    .chg_ready    (chg_ready),
    .chg_valid    (chg_valid),
    .chg_coin     (chg_coin),
    .credit       (credit),
    .state        (state),
    .vend_pulse   (vend_pulse),
    .vend_item    (vend_item),
    .coin_reject  (coin_reject),
    .error_pulse  (error_pulse),
    .err_code     (err_code),
    .stock_sel    (stock_sel),
    .sold_out_mask(sold_out_mask)
  );

  int errors = 0;
  int checks = 0;
  bit check_en = 0;
  int price_tab [NUM_ITEMS] = '{3, 7, 4, 6};

  // Transaction model: 0 idle, 1 credit, 2 vend, 3 change, 4 error.
  int m_state, m_credit, m_hold, m_idle, m_item, m_price, m_err;
  bit m_rej;
  int m_stock [NUM_ITEMS];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int greedy(input int c);
    if (c >= 5) return 5;
    if (c >= 2) return 2;
    return 1;
  endfunction

  function automatic int mask_of();
    int m = 0;
    for (int i = 0; i < NUM_ITEMS; i++) if (m_stock[i] == 0) m |= (1 << i);
    return m;
  endfunction

  task automatic model_step();
    int  nxt;
    bit  took;
    int  sel;
    if (rst) begin
      m_state = 0; m_credit = 0; m_hold = 0; m_idle = 0;
      m_item = 0; m_price = 0; m_err = 0; m_rej = 0;
      for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = MAX_STOCK;
      return;
    end
    nxt  = m_state;
    took = 0;
    sel  = int'(item_sel);
    case (m_state)
      0: if (coin_pulse && m_credit + int'(coin_value) <= MAX_CREDIT) begin
           m_credit += int'(coin_value);
           took = 1; m_idle = 0; nxt = 1;
         end
      1: if (cancel) nxt = 3;
         else if (coin_pulse) begin
           m_idle = 0;
           if (m_credit + int'(coin_value) <= MAX_CREDIT) begin
             m_credit += int'(coin_value);
             took = 1;
           end
         end else if (purchase) begin
           m_idle = 0; m_item = sel; m_price = price_tab[sel];
           if (m_stock[sel] == 0) begin nxt = 4; m_err = 1; m_hold = ERR_HOLD; end
           else if (m_credit < m_price) begin nxt = 4; m_err = 2; m_hold = ERR_HOLD; end
           else nxt = 2;
         end else begin
           m_idle++;
           if (m_idle == TIMEOUT_CYC) nxt = 3;
         end
      2: begin
           m_stock[m_item]--;
           m_credit -= m_price;
           nxt = (m_credit > 0) ? 3 : 0;
         end
      3: if (m_credit == 0) nxt = 0;
         else if (chg_ready) begin
           m_credit -= greedy(m_credit);
           if (m_credit == 0) nxt = 0;
         end
      4: begin
           m_hold--;
           if (m_hold == 0) begin nxt = (m_credit > 0) ? 1 : 0; m_idle = 0; end
         end
      default: nxt = 0;
    endcase
    m_rej = coin_pulse && !took;
    if (restock) for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = MAX_STOCK;
    m_state = nxt;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check("m_state", int'(state), m_state);
      check("m_credit", int'(credit), m_credit);
      check("m_chg_valid", int'(chg_valid), (m_state == 3 && m_credit > 0) ? 1 : 0);
      check("m_chg_coin", int'(chg_coin), (m_state == 3 && m_credit > 0) ? greedy(m_credit) : 0);
      check("m_vend_pulse", int'(vend_pulse), (m_state == 2) ? 1 : 0);
      check("m_vend_item", int'(vend_item), (m_state == 2) ? m_item : 0);
      check("m_coin_reject", int'(coin_reject), int'(m_rej));
      check("m_error_pulse", int'(error_pulse), (m_state == 4 && m_hold == ERR_HOLD) ? 1 : 0);
      check("m_err_code", int'(err_code), m_err);
      check("m_stock_sel", int'(stock_sel), m_stock[int'(item_sel)]);
      check("m_sold_out", int'(sold_out_mask), mask_of());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    coin_pulse = 0; purchase = 0; cancel = 0; restock = 0;
  endtask

  task automatic coin(input int v);
    coin_pulse = 1;
    coin_value = CREDIT_W'(v);
    tick();
  endtask

  task automatic wait_state(input string nm, input int target, input int budget);
    int n = 0;
    while (int'(state) != target && n < budget) begin
      tick();
      n++;
    end
    check(nm, int'(state), target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required < 200000", $time);
    $fatal(1);
  end

  initial begin
    rst = 1; coin_pulse = 0; coin_value = 0; purchase = 0; cancel = 0; restock = 0;
    item_sel = 0; chg_ready = 1;
    for (int i = 0; i < NUM_ITEMS; i++) price_flat[i*CREDIT_W +: CREDIT_W] = CREDIT_W'(price_tab[i]);
    tick();
    tick();
    check_en = 1;
    rst = 0;
    check("rst_state", int'(state), 0);
    check("rst_credit", int'(credit), 0);
    check("rst_stock_sel", int'(stock_sel), MAX_STOCK);
    check("rst_mask", int'(sold_out_mask), 0);
    check("rst_chg_valid", int'(chg_valid), 0);

    // Buy item 1 (price 7) with 5+5, change 2 then 1.
    coin(5);
    check("t1_credit5", int'(credit), 5);
    check("t1_state_credit", int'(state), 1);
    coin(5);
    check("t1_credit10", int'(credit), 10);
    check("pin_model_credit10", m_credit, 10);
    item_sel = 1; purchase = 1; tick();
    check("t1_vend_pulse", int'(vend_pulse), 1);
    check("t1_vend_item", int'(vend_item), 1);
    tick();
    check("t1_state_change", int'(state), 3);
    check("t1_credit3", int'(credit), 3);
    check("t1_stock1", int'(stock_sel), 8);
    check("pin_model_stock1", m_stock[1], 8);
    check("t1_coin2", int'(chg_coin), 2);
    tick();
    check("t1_coin1", int'(chg_coin), 1);
    check("t1_credit1", int'(credit), 1);
    tick();
    check("t1_idle", int'(state), 0);
    check("t1_credit0", int'(credit), 0);
    check("t1_valid_low", int'(chg_valid), 0);

    // Credit ceiling at 99.
    item_sel = 0;
    coin(95);
    check("t2_credit95", int'(credit), 95);
    coin(5);
    check("t2_reject_100", int'(coin_reject), 1);
    check("t2_credit_kept", int'(credit), 95);
    coin(2);
    check("t2_credit97", int'(credit), 97);
    check("t2_no_reject", int'(coin_reject), 0);
    coin(2);
    check("t2_credit99", int'(credit), 99);
    coin(1);
    check("t2_reject_over", int'(coin_reject), 1);
    check("t2_credit99_kept", int'(credit), 99);
    cancel = 1; tick();
    check("t2_refund_state", int'(state), 3);
    check("t2_refund_coin5", int'(chg_coin), 5);
    wait_state("t2_refund_done", 0, 40);
    check("t2_credit0", int'(credit), 0);

    // Drain item 2 (price 4), then a purchase of it is a sold-out error.
    item_sel = 2;
    for (int k = 0; k < MAX_STOCK; k++) begin
      coin(4);
      purchase = 1;
      tick();
      tick();
    end
    check("t3_stock2_zero", int'(stock_sel), 0);
    check("t3_mask", int'(sold_out_mask), 4);
    coin(5);
    purchase = 1; tick();
    check("t3_err_state", int'(state), 4);
    check("t3_err_pulse", int'(error_pulse), 1);
    check("t3_err_code1", int'(err_code), 1);
    repeat (ERR_HOLD - 1) tick();
    check("t3_still_err", int'(state), 4);
    check("t3_pulse_once", int'(error_pulse), 0);
    tick();
    check("t3_back_credit", int'(state), 1);
    check("t3_credit_kept", int'(credit), 5);
    check("t3_code_held", int'(err_code), 1);

    // Insufficient funds, then refund with a stalled dispenser.
    cancel = 1; tick();
    wait_state("t4_drain", 0, 10);
    coin(3);
    item_sel = 3; purchase = 1; tick();
    check("t4_err_state", int'(state), 4);
    check("t4_err_code2", int'(err_code), 2);
    wait_state("t4_back_credit", 1, ERR_HOLD + 4);
    check("t4_credit3", int'(credit), 3);
    chg_ready = 0;
    cancel = 1; tick();
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", int'(chg_valid), 1);
      check("t4_hold_coin2", int'(chg_coin), 2);
      if (k == 3) check("t4_reject_in_change", int'(coin_reject), 1);
      if (k == 2) begin coin_pulse = 1; coin_value = 1; purchase = 1; end
      tick();
    end
    check("t4_credit_unpaid", int'(credit), 3);
    chg_ready = 1;
    tick();
    check("t4_credit1", int'(credit), 1);
    check("t4_coin1", int'(chg_coin), 1);
    tick();
    check("t4_idle", int'(state), 0);

    // Inactivity timeout refunds two 5-coins.
    coin(10);
    repeat (TIMEOUT_CYC - 1) tick();
    check("t5_before_timeout", int'(state), 1);
    tick();
    check("t5_timeout_change", int'(state), 3);
    check("t5_coin5", int'(chg_coin), 5);
    tick();
    check("t5_credit5", int'(credit), 5);
    tick();
    check("t5_idle", int'(state), 0);
    check("t5_credit0", int'(credit), 0);

    // Restock wins over the VEND decrement of item 0.
    item_sel = 0;
    coin(3);
    purchase = 1; tick();
    check("t6_vend_pulse", int'(vend_pulse), 1);
    restock = 1; tick();
    check("t6_stock0_full", int'(stock_sel), MAX_STOCK);
    check("t6_mask_clear", int'(sold_out_mask), 0);
    check("t6_idle", int'(state), 0);

    // Reset in the middle of a change payout.
    coin(9);
    cancel = 1; tick();
    chg_ready = 0;
    tick();
    check("t7_in_change", int'(chg_valid), 1);
    rst = 1; tick();
    rst = 0;
    check("t7_state", int'(state), 0);
    check("t7_credit", int'(credit), 0);
    check("t7_chg_valid", int'(chg_valid), 0);
    chg_ready = 1;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
